// File: rtl/pwr_fault_log_pkg.sv
// Shared constants for the power fault logger: fault codes, entry layout and sequencer states.
package pwr_fault_log_pkg;

    localparam int unsigned N_FLT   = 7;
    localparam int unsigned CODE_W  = 3;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned TS_LSB  = 0;

    typedef enum logic [CODE_W-1:0] {
        FLT_AUX_SEQ   = 3'd0,
        FLT_FAN_SEQ   = 3'd1,
        FLT_N1N2_SEQ  = 3'd2,
        FLT_PERST_SEQ = 3'd3,
        FLT_AUX_RT    = 3'd4,
        FLT_FAN_RT    = 3'd5,
        FLT_N1N2_RT   = 3'd6
    } flt_code_e;

    typedef enum logic [STATE_W-1:0] {
        SEQ_OFF     = 4'h0,
        SEQ_AUX_ON  = 4'h1,
        SEQ_FAN_ON  = 4'h2,
        SEQ_N1N2_ON = 4'h3,
        SEQ_PERST   = 4'h4,
        SEQ_RUN     = 4'h5,
        SEQ_FAULT   = 4'h6
    } seq_state_e;

    // Entry layout is {code, state, timestamp}; offsets depend on the timestamp width.
    function automatic int unsigned entry_w(input int unsigned ts_w);
        return CODE_W + STATE_W + ts_w;
    endfunction

    function automatic int unsigned state_lsb(input int unsigned ts_w);
        return TS_LSB + ts_w;
    endfunction

    function automatic int unsigned code_lsb(input int unsigned ts_w);
        return TS_LSB + ts_w + STATE_W;
    endfunction

endpackage

// File: rtl/fault_fifo.sv
// Synchronous FIFO with push/pop/flush; the head reads as zero while empty.
module fault_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 23,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full, push_ok, pop_ok;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    always_comb begin
        full    = (count_q == CW'(DEPTH));
        pop_ok  = pop_i && (count_q != '0);
        push_ok = push_i && !flush_i && (!full || pop_ok);
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush_i) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push_ok) wr_d = wr_q + 1'b1;
            if (pop_ok)  rd_d = rd_q + 1'b1;
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q] <= data_i;
    end

    assign head_o  = (count_q != '0) ? mem_q[rd_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/pwr_fault_log.sv
// Power fault event logger: edge-detects active-low fault flags, timestamps them and
// queues them in a FIFO, keeping a frozen copy of the first fault since reset/clear.
module pwr_fault_log
    import pwr_fault_log_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned TS_W     = 16,
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1,
    localparam int unsigned ENTRY_W = entry_w(TS_W)
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iTick_1ms,
    input  logic [N_FLT-1:0]   iFLT_N,
    input  logic [STATE_W-1:0] iSeq_State,
    input  logic               iClear,
    output logic               oRd_Valid,
    output logic [ENTRY_W-1:0] oRd_Data,
    input  logic               iRd_Ready,
    output logic [CNT_W-1:0]   oCount,
    output logic               oOverflow,
    output logic               oFirst_Valid,
    output logic [ENTRY_W-1:0] oFirst_Data,
    output logic               oFault_Any_N
);

    logic [N_FLT-1:0]   prev_q, pend_q, pend_d, det, svc_mask;
    logic [TS_W-1:0]    ts_q, ts_d;
    logic               ovf_q, ovf_d, first_v_q, first_v_d, any_n_q;
    logic [ENTRY_W-1:0] first_q, first_d, entry;
    logic [CODE_W-1:0]  svc_code;
    logic               svc, pop, full, push;

    // Lowest-index pending flag wins; scanning downward leaves the lowest one last.
    always_comb begin
        svc      = 1'b0;
        svc_code = '0;
        svc_mask = '0;
        for (int i = int'(N_FLT) - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                svc         = 1'b1;
                svc_code    = CODE_W'(i);
                svc_mask    = '0;
                svc_mask[i] = 1'b1;
            end
        end
    end

    assign det   = ~iFLT_N & prev_q;
    assign entry = {svc_code, iSeq_State, ts_q};
    assign pop   = oRd_Valid && iRd_Ready;
    assign full  = (oCount == CNT_W'(DEPTH));
    assign push  = svc && (!full || pop);

    // Next-state for pending flags, timestamp and sticky status.
    always_comb begin
        pend_d    = (pend_q & ~svc_mask) | (det & ~pend_q);
        ts_d      = ts_q;
        ovf_d     = ovf_q | (svc && !push);
        first_v_d = first_v_q;
        first_d   = first_q;
        if (iTick_1ms && (ts_q != '1)) ts_d = ts_q + 1'b1;
        if (svc && !first_v_q) begin
            first_v_d = 1'b1;
            first_d   = entry;
        end
        if (iClear) begin
            pend_d    = '0;
            ts_d      = '0;
            ovf_d     = 1'b0;
            first_v_d = 1'b0;
            first_d   = '0;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            prev_q    <= '1;
            pend_q    <= '0;
            ts_q      <= '0;
            ovf_q     <= 1'b0;
            first_v_q <= 1'b0;
            first_q   <= '0;
            any_n_q   <= 1'b1;
        end else begin
            prev_q    <= iFLT_N;
            pend_q    <= pend_d;
            ts_q      <= ts_d;
            ovf_q     <= ovf_d;
            first_v_q <= first_v_d;
            first_q   <= first_d;
            any_n_q   <= &iFLT_N;
        end
    end

    fault_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i   (iClk),
        .rst_i   (iRst),
        .flush_i (iClear),
        .push_i  (push),
        .data_i  (entry),
        .pop_i   (pop),
        .head_o  (oRd_Data),
        .count_o (oCount)
    );

    assign oRd_Valid    = (oCount != '0);
    assign oOverflow    = ovf_q;
    assign oFirst_Valid = first_v_q;
    assign oFirst_Data  = first_q;
    assign oFault_Any_N = any_n_q;

endmodule

// File: tb/tb_pwr_fault_log.sv
// Bench for pwr_fault_log: hand-checked vector table, directed corner sequences and
// randomized traffic compared against a queue-based reference model every cycle.
module tb_pwr_fault_log;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TS_W  = 16;
    localparam int unsigned EW    = 3 + 4 + TS_W;

    logic          clk = 1'b0;
    logic          rst, clr, tick, rdy;
    logic [6:0]    flt;
    logic [3:0]    st;
    logic          rd_valid, ovf, fv, anyn;
    logic [EW-1:0] rd_data, fd;
    logic [2:0]    count;

    always #5 clk = ~clk;

    pwr_fault_log #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .iClk         (clk),
        .iRst         (rst),
        .iTick_1ms    (tick),
        .iFLT_N       (flt),
        .iSeq_State   (st),
        .iClear       (clr),
        .oRd_Valid    (rd_valid),
        .oRd_Data     (rd_data),
        .iRd_Ready    (rdy),
        .oCount       (count),
        .oOverflow    (ovf),
        .oFirst_Valid (fv),
        .oFirst_Data  (fd),
        .oFault_Any_N (anyn)
    );

    // Reference model: stored entries as a queue, pending faults as a flag array.
    logic [EW-1:0] m_q [$];
    logic [6:0]    m_prev, m_pend;
    int            m_ts;
    bit            m_ovf, m_fv, m_anyn;
    logic [EW-1:0] m_fd;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        int            svc;
        logic [6:0]    det;
        logic [EW-1:0] e;
        bit            popped;
        if (rst) begin
            m_q.delete();
            m_prev = '1; m_pend = '0; m_ts = 0;
            m_ovf = 0; m_fv = 0; m_fd = '0; m_anyn = 1;
            return;
        end
        popped = rdy && (m_q.size() != 0);
        svc = -1;
        for (int i = 0; i < 7; i++) if (m_pend[i] && svc < 0) svc = i;
        det = ~flt & m_prev;
        if (clr) begin
            m_q.delete();
            m_pend = '0; m_ts = 0; m_ovf = 0; m_fv = 0; m_fd = '0;
        end else begin
            if (popped) void'(m_q.pop_front());
            if (svc >= 0) begin
                e = {3'(svc), st, TS_W'(m_ts)};
                if (m_q.size() < DEPTH) m_q.push_back(e);
                else m_ovf = 1;
                if (!m_fv) begin m_fd = e; m_fv = 1; end
            end
            for (int i = 0; i < 7; i++) begin
                if (svc == i) m_pend[i] = 1'b0;
                else          m_pend[i] = m_pend[i] | det[i];
            end
            if (tick && m_ts < 65535) m_ts++;
        end
        m_prev = flt;
        m_anyn = &flt;
    endtask

    task automatic check_model();
        logic [EW-1:0] head;
        head = (m_q.size() != 0) ? m_q[0] : '0;
        chk("m_valid", 64'(rd_valid), 64'(m_q.size() != 0));
        chk("m_count", 64'(count), 64'(m_q.size()));
        chk("m_data", 64'(rd_data), 64'(head));
        chk("m_ovf", 64'(ovf), 64'(m_ovf));
        chk("m_fvalid", 64'(fv), 64'(m_fv));
        chk("m_fdata", 64'(fd), 64'(m_fd));
        chk("m_anyn", 64'(anyn), 64'(m_anyn));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic do_clear();
        clr = 1; flt = 7'h7F; rdy = 0; tick = 0;
        step();
        clr = 0;
    endtask

    typedef struct {
        bit            rst, tick, rdy;
        logic [6:0]    flt;
        bit            ev;
        logic [2:0]    ec;
        logic [EW-1:0] ed;
        bit            ea, efv;
        logic [EW-1:0] efd;
    } vec_t;

    function automatic vec_t mk(bit r, bit t, bit y, logic [6:0] f, bit v, logic [2:0] c,
                                logic [EW-1:0] d, bit a, bit fvl, logic [EW-1:0] fdd);
        vec_t x;
        x.rst = r; x.tick = t; x.rdy = y; x.flt = f;
        x.ev = v; x.ec = c; x.ed = d; x.ea = a; x.efv = fvl; x.efd = fdd;
        return x;
    endfunction

    localparam logic [EW-1:0] E1 = {3'd1, 4'h5, 16'd5};

    initial begin
        vec_t tbl[14];
        rst = 1; clr = 0; tick = 0; rdy = 0; flt = 7'h7F; st = 4'h5;

        // Single-event latency: bit 1 falls at cycle 10 with timestamp 5.
        tbl[0] = mk(1, 0, 0, 7'h7F, 0, 0, '0, 1, 0, '0);
        for (int i = 1; i <= 5; i++)  tbl[i] = mk(0, 1, 0, 7'h7F, 0, 0, '0, 1, 0, '0);
        for (int i = 6; i <= 10; i++) tbl[i] = mk(0, 0, 0, 7'h7F, 0, 0, '0, 1, 0, '0);
        tbl[11] = mk(0, 0, 0, 7'h7D, 0, 0, '0, 0, 0, '0);
        tbl[12] = mk(0, 0, 0, 7'h7D, 1, 1, E1, 0, 1, E1);
        tbl[13] = mk(0, 0, 1, 7'h7F, 0, 0, '0, 1, 1, E1);
        for (int i = 0; i < 14; i++) begin
            rst = tbl[i].rst; tick = tbl[i].tick; rdy = tbl[i].rdy; flt = tbl[i].flt;
            step();
            chk($sformatf("v%0d_valid", i), 64'(rd_valid), 64'(tbl[i].ev));
            chk($sformatf("v%0d_count", i), 64'(count), 64'(tbl[i].ec));
            chk($sformatf("v%0d_data", i), 64'(rd_data), 64'(tbl[i].ed));
            chk($sformatf("v%0d_anyn", i), 64'(anyn), 64'(tbl[i].ea));
            chk($sformatf("v%0d_fvalid", i), 64'(fv), 64'(tbl[i].efv));
            chk($sformatf("v%0d_fdata", i), 64'(fd), 64'(tbl[i].efd));
        end
        rdy = 0;

        // Simultaneous falls on bits 6, 2, 4 drain in code order.
        do_clear();
        flt = 7'h2B;
        repeat (4) step();
        chk("simul_count", 64'(count), 64'd3);
        chk("simul_first", 64'(fd[EW-1 -: 3]), 64'd2);
        rdy = 1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("simul_rd%0d", k), 64'(rd_data[EW-1 -: 3]), 64'(2 + 2 * k));
            step();
        end
        chk("simul_empty", 64'(rd_valid), 64'd0);
        flt = 7'h7F; rdy = 0; step();

        // Overflow: five events into a four-deep FIFO.
        do_clear();
        flt = 7'h60;
        repeat (6) step();
        chk("ovf_count", 64'(count), 64'd4);
        chk("ovf_flag", 64'(ovf), 64'd1);
        chk("ovf_first", 64'(fd[EW-1 -: 3]), 64'd0);
        rdy = 1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ovf_rd%0d", k), 64'(rd_data[EW-1 -: 3]), 64'(k));
            step();
        end
        chk("ovf_empty", 64'(rd_valid), 64'd0);
        flt = 7'h7F; rdy = 0; step();

        // Full FIFO: push and pop in the same cycle.
        do_clear();
        flt = 7'h70;
        repeat (5) step();
        chk("full_count", 64'(count), 64'd4);
        flt = 7'h50; step();
        rdy = 1; step();
        rdy = 0;
        chk("pp_count", 64'(count), 64'd4);
        chk("pp_ovf", 64'(ovf), 64'd0);
        rdy = 1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("pp_rd%0d", k), 64'(rd_data[EW-1 -: 3]), 64'((k < 3) ? k + 1 : 5));
            step();
        end
        chk("pp_empty", 64'(rd_valid), 64'd0);
        flt = 7'h7F; rdy = 0; step();

        // Clear colliding with a bit-0 fall while two entries are stored.
        do_clear();
        tick = 1; flt = 7'h1F;
        repeat (3) step();
        chk("clr_pre_count", 64'(count), 64'd2);
        tick = 0; clr = 1; flt = 7'h1E;
        step();
        clr = 0;
        chk("clr_count", 64'(count), 64'd0);
        chk("clr_fvalid", 64'(fv), 64'd0);
        repeat (3) step();
        chk("clr_nolog", 64'(count), 64'd0);
        st = 4'hA; flt = 7'h16;
        repeat (2) step();
        chk("clr_ts0", 64'(rd_data), 64'({3'd3, 4'hA, 16'd0}));
        flt = 7'h7F; rdy = 1; step(); rdy = 0; step();

        // Timestamp saturation, then reset mid-readout.
        do_clear();
        tick = 1;
        repeat (70000) step();
        tick = 0; st = 4'h3; flt = 7'h6B;
        repeat (3) step();
        chk("sat_entry", 64'(rd_data), 64'({3'd2, 4'h3, 16'hFFFF}));
        chk("sat_count", 64'(count), 64'd2);
        rdy = 1; step();
        rst = 1; step();
        rst = 0; rdy = 0;
        chk("rst_valid", 64'(rd_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_data", 64'(rd_data), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_fvalid", 64'(fv), 64'd0);
        chk("rst_fdata", 64'(fd), 64'd0);
        chk("rst_anyn", 64'(anyn), 64'd1);
        // Flags still low at reset release are logged as fresh events.
        repeat (2) step();
        chk("rel_count", 64'(count), 64'd1);
        chk("rel_code", 64'(rd_data[EW-1 -: 3]), 64'd2);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(0, 299) == 0);
            clr  = ($urandom_range(0, 59) == 0);
            tick = ($urandom_range(0, 3) == 0);
            rdy  = ($urandom_range(0, 2) == 0);
            st   = 4'($urandom);
            for (int b = 0; b < 7; b++) if ($urandom_range(0, 9) == 0) flt[b] = ~flt[b];
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwr_fault_log.md
PWR_FAULT_LOG -- requirements
Module: pwr_fault_log

Interface
REQ-001 The module SHALL have the parameter DEPTH, default 4, setting the number of event FIFO entries (power of two, minimum 2).
REQ-002 The module SHALL have the parameter TS_W, default 16, setting the width of the millisecond timestamp.
REQ-003 The module SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port iClk, input, 1 bit: module clock, the same 2 MHz clock that drives the master sequencer.
REQ-005 Port iRst, input, 1 bit: synchronous active-high reset.
REQ-006 Port iTick_1ms, input, 1 bit: single-cycle enable, asserted once per millisecond, synchronous to iClk.
REQ-007 Port iFLT_N, input, 7 bits: active-low fault flags, assigned as follows.
- [0] P12V_AUX_SEQPWR
- [1] P12V_FAN_SEQPWR
- [2] P12V_N1N2_SEQPWR
- [3] Host_PERST_SEQPWR
- [4] P12V_AUX_RUNTIME
- [5] P12V_FAN_RUNTIME
- [6] P12V_N1N2_RUNTIME
REQ-008 Port iSeq_State, input, 4 bits: current master-sequencer state code.
REQ-009 Port iClear, input, 1 bit: synchronous log clear, driven by the BMC.
REQ-010 Port oRd_Valid, output, 1 bit: FIFO head is valid.
REQ-011 Port oRd_Data, output, 3+4+TS_W bits: head entry as {code[2:0], state[3:0], timestamp}.
REQ-012 Port iRd_Ready, input, 1 bit: consumer accepts the head entry.
REQ-013 Port oCount, output, clog2(DEPTH)+1 bits: FIFO occupancy.
REQ-014 Port oOverflow, output, 1 bit: sticky flag, set when an event was dropped.
REQ-015 Port oFirst_Valid, output, 1 bit: the first-fault record is valid.
REQ-016 Port oFirst_Data, output, 3+4+TS_W bits: first-fault record, same format as oRd_Data.
REQ-017 Port oFault_Any_N, output, 1 bit: low while any iFLT_N bit is low (registered).

Function
REQ-018 The timestamp counter SHALL increment on each iClk edge where iTick_1ms=1, saturate at all-ones, and clear to 0 on iClear.
REQ-019 A fault event SHALL be detected on bit i when iFLT_N[i]=0 is sampled and the previous-sample register bit is 1.
REQ-020 The previous-sample register SHALL update every cycle, including cycles with iClear=1.
REQ-021 A detected event SHALL set pend[i] at the end of the detection cycle.
REQ-022 A new event on a bit whose pend bit is already set SHALL merge with the existing pending event (no second entry).
REQ-023 Each cycle, the arbiter SHALL service the lowest-index set pend bit, at most one per cycle.
REQ-024 Servicing SHALL build the entry {i, iSeq_State, timestamp}, using values sampled in the service cycle, and clear pend[i].
REQ-025 If the FIFO is not full, or a pop occurs in the same cycle, the serviced entry SHALL be pushed.
REQ-026 Otherwise the entry SHALL be dropped, oOverflow SHALL be set, and pend[i] SHALL still clear.
REQ-027 Latency: an event sampled in cycle k SHALL produce oRd_Valid=1 in cycle k+2 when it is the only pending bit and the FIFO was empty.
REQ-028 oRd_Valid SHALL equal (occupancy != 0).
REQ-029 oRd_Data SHALL show the oldest entry.
REQ-030 A pop SHALL occur when oRd_Valid && iRd_Ready.
REQ-031 oRd_Data SHALL be held stable while oRd_Valid=1 and iRd_Ready=0.
REQ-032 On a simultaneous push and pop, occupancy SHALL be unchanged and the FIFO pointers SHALL wrap modulo DEPTH.
REQ-033 A pop when empty SHALL be ignored.
REQ-034 The first push after reset or clear SHALL copy its entry into oFirst_Data and set oFirst_Valid.
REQ-035 oFirst_Data SHALL be frozen until reset or clear; a dropped entry SHALL still load the first record if oFirst_Valid=0.
REQ-036 iClear=1 SHALL empty the FIFO and clear pend, oOverflow, oFirst_Valid, oFirst_Data and the timestamp, taking effect at the end of that cycle.
REQ-037 An event detected in the same cycle as iClear=1 SHALL be discarded.
REQ-038 Priority SHALL be iRst > iClear > normal operation.
REQ-039 oFault_Any_N SHALL be registered, with 1-cycle latency from iFLT_N.

Reset
REQ-040 On iRst=1, the module SHALL drive these values.
- previous-sample register = 7'h7F
- pend = 0, FIFO empty, oCount = 0, oRd_Valid = 0, oRd_Data = 0
- oOverflow = 0, oFirst_Valid = 0, oFirst_Data = 0
- timestamp = 0, oFault_Any_N = 1
REQ-041 A flag already low when reset is released SHALL be logged as an event in the first post-reset cycle.
REQ-042 Reset asserted mid-operation SHALL discard all pending and stored entries within the same cycle.

Structure
REQ-043 Package pwr_fault_log_pkg SHALL hold the fault code constants FLT_AUX_SEQ=0 through FLT_N1N2_RT=6, the entry field widths/offsets, and the sequencer state code constants.
REQ-044 The storage SHALL be one sub-module, fault_fifo: a synchronous FIFO with push/pop/flush, parameterized by DEPTH and width.

Verification
REQ-045 Scenario, single event with latency check.
- Stimulus: after reset with iFLT_N=7'h7F, drive iFLT_N[1]=0 at cycle 10, timestamp=5, iSeq_State=4'h5.
- Required: oRd_Valid=1 at cycle 12, oRd_Data={3'd1,4'h5,16'd5}, oFirst_Data identical, oFault_Any_N=0 at cycle 11.
REQ-046 Scenario, simultaneous events.
- Stimulus: bits 6, 2 and 4 fall in the same cycle.
- Required: three entries pushed in code order 2, 4, 6 on consecutive cycles; oCount=3; oFirst code=2.
REQ-047 Scenario, overflow with DEPTH=4 and iRd_Ready=0.
- Stimulus: 5 distinct events.
- Required: oCount=4, oOverflow=1, 5th entry absent, oFirst unchanged.
- Then with iRd_Ready=1: entries 0-3 read out in order, then oRd_Valid=0.
REQ-048 Scenario, full FIFO with simultaneous push and pop.
- Stimulus: FIFO full, new event serviced in the same cycle as a pop.
- Required: oCount stays 4, no overflow, new entry appears last after wrap.
REQ-049 Scenario, clear collision.
- Stimulus: iClear=1 in the same cycle as a bit-0 falling edge, with 2 entries stored.
- Required: next cycle oCount=0, oFirst_Valid=0, timestamp=0; bit 0 is not logged afterwards while it stays low.
REQ-050 Scenario, timestamp saturation and reset mid-operation.
- Stimulus: 70000 ticks, then an event.
- Required: logged timestamp=16'hFFFF.
- Stimulus: then iRst=1 mid-readout.
- Required: all outputs at REQ-040 values the next cycle.
